// File: rtl/onehot_decoder_fifo_pkg.sv
// ----------------------------------------------------------------------------
// onehot_dec_pkg
//   Shared types and helpers for the buffered 3-to-8 one-hot decoder.
//   - CODE_W / ONEHOT_W : encoded index width and decoded word width
//   - code_t            : one FIFO entry (code, plus a 'none' flag when
//                         ONEHOT_DEC_NONE_EN is defined)
//   - decode_onehot()   : entry -> one-hot word
// Build option: ONEHOT_DEC_NONE_EN adds the 'none' flag to each entry.
// ----------------------------------------------------------------------------
package onehot_dec_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

`ifdef ONEHOT_DEC_NONE_EN
  // 'none' separates "no encoder input active" from "input 0 active";
  // the encoder emits code 000 for both.
  typedef struct packed {
    logic              none;
    logic [CODE_W-1:0] code;
  } code_t;
`else
  typedef struct packed {
    logic [CODE_W-1:0] code;
  } code_t;
`endif

  localparam int ENTRY_W = $bits(code_t);

  function automatic logic [ONEHOT_W-1:0] decode_onehot(input code_t e);
    logic [ONEHOT_W-1:0] w;
    w = ONEHOT_W'(1) << e.code;
`ifdef ONEHOT_DEC_NONE_EN
    if (e.none) w = '0;
`endif
    return w;
  endfunction

endpackage

// File: rtl/onehot_decoder_fifo_if.sv
// ----------------------------------------------------------------------------
// onehot_decoder_fifo_if
//   Bundles the producer-side and consumer-side handshakes of the decoder.
//   Producer: in_valid, in_ready, a/b/c (code, a = MSB), none (optional)
//   Consumer: out_valid, out_ready, y (one-hot), count (occupancy)
//   modport slave  : the decoder block's view
//   modport master : the surrounding producer/consumer view
// Build option: ONEHOT_DEC_NONE_EN adds the 'none' signal.
// ----------------------------------------------------------------------------
interface onehot_decoder_fifo_if
  import onehot_dec_pkg::*;
#(
  parameter int DEPTH = 4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                in_valid;
  logic                in_ready;
  logic                a;
  logic                b;
  logic                c;
`ifdef ONEHOT_DEC_NONE_EN
  logic                none;
`endif
  logic                out_valid;
  logic                out_ready;
  logic [ONEHOT_W-1:0] y;
  logic [CNT_W-1:0]    count;

  modport slave (
`ifdef ONEHOT_DEC_NONE_EN
    input  none,
`endif
    input  in_valid, a, b, c, out_ready,
    output in_ready, out_valid, y, count
  );

  modport master (
`ifdef ONEHOT_DEC_NONE_EN
    output none,
`endif
    output in_valid, a, b, c, out_ready,
    input  in_ready, out_valid, y, count
  );

endinterface

// File: rtl/onehot_decoder_fifo_code_fifo.sv
// ----------------------------------------------------------------------------
// code_fifo
//   Synchronous FIFO with registered pointers and occupancy count.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     push_i, wdata_i : write request and data (ignored when full)
//     pop_i           : read request (ignored when empty)
//     rdata_o         : head entry (valid while !empty_o)
//     count_o         : occupancy, 0..DEPTH
//     full_o, empty_o : occupancy flags decoded from the registered count
//   DEPTH must be a power of two so the pointers wrap by overflow.
// ----------------------------------------------------------------------------
module code_fifo #(
  parameter  int WIDTH = 3,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;  // idle, or push and pop together
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; count and pointers decide which
  // entries are live, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/onehot_decoder_fifo.sv
// ----------------------------------------------------------------------------
// onehot_decoder_fifo
//   Buffered 3-to-8 decoder. Encoded indices {a,b,c} are queued in a
//   code_fifo and presented in order as one-hot words on y.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : onehot_decoder_fifo_if.slave
//                  in_valid/in_ready/a/b/c[/none] producer handshake
//                  out_valid/out_ready/y consumer handshake, count occupancy
//   in_ready depends only on the registered count (never on out_ready), and
//   there is no empty bypass or full pass-through.
// Build option: ONEHOT_DEC_NONE_EN adds the 'none' input; entries stored with
//   none=1 pop normally with y = 8'h00.
// ----------------------------------------------------------------------------
module onehot_decoder_fifo
  import onehot_dec_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  onehot_decoder_fifo_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  code_t            wr_entry;
  code_t            head_entry;
  logic [ENTRY_W-1:0] head_raw;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  always_comb begin
    wr_entry      = '0;
    wr_entry.code = {bus.a, bus.b, bus.c};
`ifdef ONEHOT_DEC_NONE_EN
    wr_entry.none = bus.none;
`endif
  end

  assign push = bus.in_valid && !fifo_full;
  assign pop  = bus.out_ready && !fifo_empty;

  code_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_code_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head_raw),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_entry    = code_t'(head_raw);
  assign bus.in_ready  = !fifo_full;
  assign bus.out_valid = !fifo_empty;
  assign bus.count     = fifo_count;
  // The head slot holds stale data when empty, so y is gated to zero.
  assign bus.y         = fifo_empty ? '0 : decode_onehot(head_entry);

endmodule

// File: tb/tb_onehot_decoder_fifo.sv
// ----------------------------------------------------------------------------
// tb_onehot_decoder_fifo
//   Scoreboard bench for onehot_decoder_fifo (DEPTH = 4). Accepted codes are
//   turned into expected one-hot words and queued; each pop is compared
//   against the queue head, and occupancy/flags against the queue size.
// Build option: ONEHOT_DEC_NONE_EN enables the 'none' scenario.
// ----------------------------------------------------------------------------
module tb_onehot_decoder_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk;
  logic rst_n;

  onehot_decoder_fifo_if #(.DEPTH(DEPTH)) bus ();

  onehot_decoder_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_pops = 0;
  int         max_cnt = 0;
  logic [7:0] sb_q[$];

  function automatic logic [7:0] exp_word(input logic [2:0] code, input logic nn);
    logic [7:0] w;
    w = 8'h00;
    if (!nn) w[code] = 1'b1;
    return w;
  endfunction

  task automatic drive(input logic v, input logic [2:0] code, input logic nn);
    bus.in_valid = v;
    {bus.a, bus.b, bus.c} = code;
`ifdef ONEHOT_DEC_NONE_EN
    bus.none = nn;
`endif
  endtask

  // Scoreboard monitor, sampling on the falling edge away from updates.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [7:0] exp;
      n_cmp++;
      if (bus.out_valid !== (sb_q.size() != 0)) begin
        n_err++;
        $display("FAIL out_valid: got %b want %b", bus.out_valid, sb_q.size() != 0);
      end
      n_cmp++;
      if (bus.in_ready !== (sb_q.size() != DEPTH)) begin
        n_err++;
        $display("FAIL in_ready: got %b want %b", bus.in_ready, sb_q.size() != DEPTH);
      end
      n_cmp++;
      if (bus.count !== CNT_W'(sb_q.size())) begin
        n_err++;
        $display("FAIL count: got %0d want %0d", bus.count, sb_q.size());
      end
      if (!bus.out_valid) begin
        n_cmp++;
        if (bus.y !== 8'h00) begin
          n_err++;
          $display("FAIL y_idle: got %h want 00", bus.y);
        end
      end
      if (bus.count > max_cnt) max_cnt = int'(bus.count);
      if (bus.out_valid && bus.out_ready) begin
        n_pops++;
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL pop_empty: got y=%h want no pop", bus.y);
        end else begin
          exp = sb_q.pop_front();
          if (bus.y !== exp) begin
            n_err++;
            $display("FAIL y_order: got %h want %h", bus.y, exp);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
`ifdef ONEHOT_DEC_NONE_EN
        sb_q.push_back(exp_word({bus.a, bus.b, bus.c}, bus.none));
`else
        sb_q.push_back(exp_word({bus.a, bus.b, bus.c}, 1'b0));
`endif
      end
    end
  end

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0 && bus.count == '0) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_drain: got count=%0d want 0 within 20 cycles", name, bus.count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 3'd0, 1'b0);
    #3;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.y !== 8'h00) begin n_err++; $display("FAIL rst_y: got %h want 00", bus.y); end
    n_cmp++; if (bus.count !== '0) begin n_err++; $display("FAIL rst_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    #9 rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    max_cnt = 0;
    n_pops  = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 3'(i), 1'b0);
    end
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 1'b0);
    @(posedge clk); #1;
    n_cmp++; if (n_pops != 8) begin n_err++; $display("FAIL b2b_pops: got %0d want 8", n_pops); end
    n_cmp++; if (max_cnt > 1) begin n_err++; $display("FAIL b2b_max_count: got %0d want <=1", max_cnt); end
    drain("b2b");
  endtask

  task automatic test_full_stall();
    logic [2:0] codes [5] = '{3'd3, 3'd6, 3'd1, 3'd7, 3'd2};
    bus.out_ready = 1'b0;
    n_pops = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(1'b1, codes[i], 1'b0);
    end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.count !== CNT_W'(4)) begin n_err++; $display("FAIL full_count: got %0d want 4", bus.count); end
    @(posedge clk); #1;
    n_cmp++; if (bus.count !== CNT_W'(4)) begin n_err++; $display("FAIL full_hold_count: got %0d want 4", bus.count); end
    // Pop while full with in_valid still high: no push that cycle.
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL full_pop_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.count !== CNT_W'(3)) begin n_err++; $display("FAIL full_pop_count: got %0d want 3", bus.count); end
    drive(1'b0, 3'd0, 1'b0);
    drain("full");
    n_cmp++; if (n_pops != 4) begin n_err++; $display("FAIL full_pops: got %0d want 4", n_pops); end
  endtask

  task automatic test_steady_state();
    bus.out_ready = 1'b0;
    @(posedge clk); #1; drive(1'b1, 3'd4, 1'b0);
    @(posedge clk); #1; drive(1'b1, 3'd5, 1'b0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'd0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.count !== CNT_W'(2)) begin
        n_err++;
        $display("FAIL steady_count[%0d]: got %0d want 2", i, bus.count);
      end
      if (i < 10) drive(1'b1, 3'((i * 3) % 8), 1'b0);
      else        drive(1'b0, 3'd0, 1'b0);
    end
    drain("steady");
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    @(posedge clk); #1; drive(1'b1, 3'd1, 1'b0);
    @(posedge clk); #1; drive(1'b1, 3'd2, 1'b0);
    @(posedge clk); #1; drive(1'b1, 3'd3, 1'b0);
    @(posedge clk); #1; drive(1'b0, 3'd0, 1'b0);
    n_cmp++; if (bus.count !== CNT_W'(3)) begin n_err++; $display("FAIL arst_pre_count: got %0d want 3", bus.count); end
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL arst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.y !== 8'h00) begin n_err++; $display("FAIL arst_y: got %h want 00", bus.y); end
    n_cmp++; if (bus.count !== '0) begin n_err++; $display("FAIL arst_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL arst_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk); #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL arst_after_out_valid: got %b want 0", bus.out_valid); end
  endtask

`ifdef ONEHOT_DEC_NONE_EN
  task automatic test_none();
    bus.out_ready = 1'b0;
    @(posedge clk); #1; drive(1'b1, 3'd0, 1'b1);
    @(posedge clk); #1; drive(1'b1, 3'd0, 1'b0);
    @(posedge clk); #1; drive(1'b0, 3'd0, 1'b0);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.y !== 8'h00) begin
      n_err++; $display("FAIL none_head: got valid=%b y=%h want valid=1 y=00", bus.out_valid, bus.y);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.y !== 8'h01) begin
      n_err++; $display("FAIL none_second: got valid=%b y=%h want valid=1 y=01", bus.out_valid, bus.y);
    end
    drain("none");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_full_stall();
    test_steady_state();
    test_async_reset();
`ifdef ONEHOT_DEC_NONE_EN
    test_none();
`endif
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
